// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// The state encoding is visible on the debug port so checkers can bind to it.
package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INHIBIT,
        REQ,
        WAIT_CLK,
        DATA,
        ACK,
        WAIT_IDLE,
        DONE,
        ERROR
    } ps2_state_t;

    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] RESP_ACK    = 8'hFA;

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake of the PS/2 transmitter.
interface ps2_host_tx_if;
    // tx_data is taken on a clock edge where tx_valid and tx_ready are both 1;
    // tx_valid outside that is ignored, never queued. done/error are 1-cycle pulses.
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_busy, tx_done, tx_error
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_busy, tx_done, tx_error
    );
endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous PS/2 pad plus falling-edge detect.
module ps2_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic fe
);
    logic meta;
    logic prev;

    // Idle PS/2 lines float high, so all stages reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign fe = prev & ~sync;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out 8 data
// bits + odd parity on device falling edges, release for stop, check the ack.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned START_TIMEOUT  = 750000,
    parameter int unsigned PACKET_TIMEOUT = 100000
) (
    input  logic          clk,
    input  logic          reset,
    ps2_host_tx_if.slave  tx,
    input  logic          ps2_clk_in,
    input  logic          ps2_dat_in,
    output logic          ps2_clk_oe,
    output logic          ps2_dat_oe,
    output ps2_state_t    dbg_state
);
    localparam int unsigned MAX_A = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int unsigned MAX_T = (MAX_A > PACKET_TIMEOUT) ? MAX_A : PACKET_TIMEOUT;
    localparam int          CW    = $clog2(MAX_T + 1);
    localparam logic [CW-1:0] INH_T   = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] START_T = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] PKT_T   = CW'(PACKET_TIMEOUT - 1);

    ps2_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par, par_n;
    logic [3:0]    bitcnt, bitcnt_n;
    logic          dat_oe, dat_oe_n;
    logic          clk_sync, clk_fe;
    logic          dat_meta, dat_sync;

    ps2_sync_edge u_clk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (ps2_clk_in),
        .sync  (clk_sync),
        .fe    (clk_fe)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            dat_meta <= ps2_dat_in;
            dat_sync <= dat_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            shreg  <= '0;
            par    <= 1'b0;
            bitcnt <= '0;
            dat_oe <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            shreg  <= shreg_n;
            par    <= par_n;
            bitcnt <= bitcnt_n;
            dat_oe <= dat_oe_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        shreg_n  = shreg;
        par_n    = par;
        bitcnt_n = bitcnt;
        dat_oe_n = dat_oe;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (tx.tx_valid) begin
                    shreg_n = tx.tx_data;
                    par_n   = ~^tx.tx_data;
                    state_n = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == INH_T) begin
                    cnt_n    = '0;
                    dat_oe_n = 1'b1;
                    state_n  = REQ;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            REQ: begin
                cnt_n   = '0;
                state_n = WAIT_CLK;
            end
            WAIT_CLK: begin
                if (clk_fe) begin
                    dat_oe_n = ~shreg[0];
                    shreg_n  = {1'b0, shreg[7:1]};
                    bitcnt_n = 4'd1;
                    cnt_n    = '0;
                    state_n  = DATA;
                end else if (cnt == START_T) begin
                    state_n = ERROR;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA, ACK, WAIT_IDLE: begin
                // One packet budget spans everything from the first device edge to DONE.
                if (cnt == PKT_T) begin
                    state_n = ERROR;
                end else begin
                    cnt_n = cnt + 1'b1;
                    if (state == DATA && clk_fe) begin
                        if (bitcnt < 4'd8) begin
                            dat_oe_n = ~shreg[0];
                            shreg_n  = {1'b0, shreg[7:1]};
                            bitcnt_n = bitcnt + 1'b1;
                        end else if (bitcnt == 4'd8) begin
                            dat_oe_n = ~par;
                            bitcnt_n = 4'd9;
                        end else begin
                            dat_oe_n = 1'b0;
                            state_n  = ACK;
                        end
                    end else if (state == ACK && clk_fe) begin
                        state_n = dat_sync ? ERROR : WAIT_IDLE;
                    end else if (state == WAIT_IDLE && clk_sync && dat_sync) begin
                        state_n = DONE;
                    end
                end
            end
            DONE:    state_n = IDLE;
            ERROR:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (state_n inside {IDLE, DONE, ERROR}) begin
            dat_oe_n = 1'b0;
        end
    end

    assign ps2_clk_oe  = (state == INHIBIT) || (state == REQ);
    assign ps2_dat_oe  = dat_oe;
    assign tx.tx_ready = (state == IDLE);
    assign tx.tx_busy  = (state != IDLE);
    assign tx.tx_done  = (state == DONE);
    assign tx.tx_error = (state == ERROR);
    assign dbg_state   = state;
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: the send direction paired with the keyboard receive path (keyboard_press_driver).
- Sends one command byte to the keyboard, for example 0xFF reset, 0xED set-LEDs or 0xF4 enable.
- Drives the open-drain PS2_CLK/PS2_DAT lines through active-high pull-low enables and reports the device acknowledge.
- Sits at top level beside keyboard_press_driver; tx_busy lets the receive path ignore edges the transmitter causes.

Parameters:
- INHIBIT_CYCLES, 6000: clk cycles PS2_CLK is held low before the request (120 us at 50 MHz).
- START_TIMEOUT, 750000: cycles allowed from clock release to the first device falling edge (15 ms).
- PACKET_TIMEOUT, 100000: cycles allowed from the first falling edge to ack complete (2 ms).

Ports:
- clk  in  1  system clock, 50 MHz (CLOCK_50 at top).
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- tx_data  in  8  command byte.
- tx_valid  in  1  request; accepted only when tx_ready=1.
- tx_ready  out  1  high only in IDLE.
- tx_busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse: byte sent and ack received.
- tx_error  out  1  one-cycle pulse: timeout or missing ack.
- ps2_clk_in  in  1  raw PS2_CLK pad value (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT pad value (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low, 0 = release.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low, 0 = release.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, ps2_clk_oe=0, ps2_dat_oe=0, tx_done=0, tx_error=0, counters=0, synchronizers=1. tx_ready=1, tx_busy=0. All outputs are registered or decoded from state.
- Pad inputs pass through a 2-FF synchronizer each. A falling edge (fe) is sync'd clk previous=1, current=0.
- On accept (tx_valid & IDLE): latch tx_data into a shift register. Latch par = ~^tx_data (odd parity). Go to INHIBIT on the next cycle.
- INHIBIT: ps2_clk_oe=1, ps2_dat_oe=0. Count INHIBIT_CYCLES, then go to REQ.
- REQ: ps2_dat_oe=1 (start bit 0) for 1 cycle with the clock still held. Then ps2_clk_oe=0 and go to WAIT_CLK.
- WAIT_CLK: first fe → drive bit d0 (ps2_dat_oe = ~d0) and go to DATA with bitcnt=1. If no fe within START_TIMEOUT cycles → ERROR.
- DATA: each fe drives the next bit, LSB first, ps2_dat_oe = ~bit.
  - After d7 is driven, the next fe drives parity: ps2_dat_oe = ~par.
  - The following fe releases data (ps2_dat_oe=0, stop bit) and goes to ACK.
- ACK: on the next fe, sample sync'd data.
  - 0 → go to WAIT_IDLE.
  - 1 → ERROR (no ack).
- WAIT_IDLE: wait until sync'd clk=1 and data=1, then go to DONE.
- PACKET_TIMEOUT applies from entry to DATA until DONE. It is checked in DATA, ACK and WAIT_IDLE; expiry → ERROR.
- DONE: tx_done=1 for one cycle, then IDLE.
- ERROR: release both lines, tx_error=1 for one cycle, then IDLE. No automatic retry.
- Edge count per byte: 11 falling edges after release (d0–d7, parity, stop, ack).
- Boundary cases:
  - tx_valid while not ready: ignored, not queued.
  - tx_valid held high: a new byte is accepted only on the cycle tx_ready=1.
  - Device already clocking a frame when tx_valid arrives: host inhibit wins and the keyboard aborts and retransmits later. The transmitter does not wait.
  - fe in IDLE or INHIBIT: ignored.
  - Reset mid-frame: lines release within the same cycle (asynchronous). No done/error pulse.
  - Counters saturate at the terminal count; no wrap.

Decomposition:
- Package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, REQ, WAIT_CLK, DATA, ACK, WAIT_IDLE, DONE, ERROR);
  - command constants CMD_RESET=8'hFF, CMD_SET_LED=8'hED, CMD_ENABLE=8'hF4, RESP_ACK=8'hFA.
- One sub-module, ps2_sync_edge: 2-FF synchronizer plus fe detect. It is instantiated for the clock line; the data line uses the synchronizer only.

Test Plan:
- Reset values: hold reset=0 mid-INHIBIT → oe outputs 0 immediately; after release, tx_ready=1, tx_busy=0.
- Send 0xED with a device model clocking at 12.5 kHz:
  - ps2_clk_oe=1 for 6000 cycles, then start bit.
  - Bits driven, LSB first: 1,0,1,1,0,1,1,1; parity 1; stop released.
  - Model acks with data low → exactly one tx_done pulse; line release and tx_done within ~2000 clk of the 11th fe (after WAIT_IDLE).
- Send 0xF4 → parity bit 0. Send 0xFF → parity 1. Check every bit against the device model's rising-edge sample.
- No device (clock stays high) → tx_error pulse exactly 750000 cycles after clock release; lines released; tx_ready=1.
- Device keeps data high at the 11th fe → tx_error pulse, no tx_done.
- tx_valid=1 asserted during DATA with tx_data=0x00 → ignored; the transmitted byte is unchanged and a second transfer starts only after IDLE.
